// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI responder: decodes link TXCMDs (transmit, register write/read) and
// turns local receive packets into ULPI receive sequences. Supports NUM_REGS up to 64.
module ulpi_phy_responder #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [7:0]  VENDOR_ID = 8'h24
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] ulpi_data_in,
  input  logic       stp,
  output logic [7:0] ulpi_data_out,
  output logic       dir,
  output logic       nxt,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       tx_last,
  output logic [3:0] tx_pid,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_last,
  output logic       rx_ready
);

  localparam int unsigned AddrW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    StIdle, StTxAck, StTxData, StWrAck, StWrData, StWrEnd, StRdAck,
    StRdTurn, StRdData, StRxTurn, StRxData, StRxEop, StRxBack
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        dir_q, dir_d;
  logic        nxt_q, nxt_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic [3:0]  tx_pid_q, tx_pid_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic        reg_we;
  logic        addr_ok;
  logic [7:0]  rd_val;

  assign addr_ok = (32'(cmd_q) < NUM_REGS);
  assign rd_val  = addr_ok ? regs_q[cmd_q[AddrW-1:0]] : 8'h00;

  always_comb begin
    regs_d = regs_q;
    if (reg_we) begin
      regs_d[cmd_q[AddrW-1:0]] = wdata_q;
    end
  end

  // Bus outputs are registered: each branch sets what the bus shows next cycle.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    wdata_d      = wdata_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    dir_d        = 1'b0;
    nxt_d        = 1'b0;
    data_d       = 8'h00;
    tx_byte_d    = tx_byte_q;
    tx_valid_d   = 1'b0;
    tx_last_d    = 1'b0;
    tx_pid_d     = tx_pid_q;
    reg_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ulpi_data_in[7:6] != 2'b00) begin
          cmd_d = ulpi_data_in[5:0];
          nxt_d = 1'b1;
          if (ulpi_data_in[7:6] == 2'b01) begin
            state_d = StTxAck;
          end else if (ulpi_data_in[7:6] == 2'b10) begin
            state_d = StWrAck;
          end else begin
            state_d = StRdAck;
          end
        end else if (rx_valid) begin
          state_d = StRxTurn;
        end
      end
      StTxAck: begin
        nxt_d        = 1'b1;
        tx_pid_d     = cmd_q[3:0];
        hold_valid_d = 1'b0;
        state_d      = StTxData;
      end
      StTxData: begin
        // One-byte skid: a byte is only known not to be last once its successor arrives.
        if (stp) begin
          if (hold_valid_q) begin
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b1;
            tx_byte_d  = hold_q;
          end
          hold_valid_d = 1'b0;
          state_d      = StIdle;
        end else begin
          nxt_d = 1'b1;
          if (hold_valid_q) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = hold_q;
          end
          hold_d       = ulpi_data_in;
          hold_valid_d = 1'b1;
        end
      end
      StWrAck: begin
        nxt_d   = 1'b1;
        state_d = StWrData;
      end
      StWrData: begin
        wdata_d = ulpi_data_in;
        state_d = StWrEnd;
      end
      StWrEnd: begin
        if (stp) begin
          reg_we  = addr_ok;
          state_d = StIdle;
        end
      end
      StRdAck: begin
        dir_d   = 1'b1;
        state_d = StRdTurn;
      end
      StRdTurn: begin
        dir_d   = 1'b1;
        data_d  = rd_val;
        state_d = StRdData;
      end
      StRdData: begin
        state_d = StIdle;
      end
      StRxTurn: begin
        dir_d   = 1'b1;
        state_d = StRxData;
      end
      StRxData: begin
        dir_d = 1'b1;
        if (rx_valid) begin
          data_d = rx_byte;
          nxt_d  = 1'b1;
          if (rx_last) begin
            state_d = StRxEop;
          end
        end else begin
          data_d = 8'h11;  // RXCMD: RxActive, LineState J
        end
      end
      StRxEop: begin
        dir_d   = 1'b1;
        data_d  = 8'h01;   // RXCMD: RxActive dropped
        state_d = StRxBack;
      end
      StRxBack: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      wdata_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      dir_q        <= 1'b0;
      nxt_q        <= 1'b0;
      data_q       <= '0;
      tx_byte_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      tx_pid_q     <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      dir_q        <= dir_d;
      nxt_q        <= nxt_d;
      data_q       <= data_d;
      tx_byte_q    <= tx_byte_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
      tx_pid_q     <= tx_pid_d;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (i == 0) ? VENDOR_ID : 8'h00;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ulpi_data_out = data_q;
  assign dir           = dir_q;
  assign nxt           = nxt_q;
  assign tx_byte       = tx_byte_q;
  assign tx_valid      = tx_valid_q;
  assign tx_last       = tx_last_q;
  assign tx_pid        = tx_pid_q;
  assign rx_ready      = (state_q == StRxData);

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Directed bench for ulpi_phy_responder: per-cycle bus expectations plus a queue of
// expected transmit bytes that is drained as tx_valid strobes appear.
module tb_ulpi_phy_responder;

  logic       clk;
  logic       n_rst;
  logic [7:0] ulpi_data_in;
  logic       stp;
  logic [7:0] ulpi_data_out;
  logic       dir;
  logic       nxt;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_last;
  logic [3:0] tx_pid;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] tx_q [$];

  ulpi_phy_responder #(
    .NUM_REGS  (16),
    .VENDOR_ID (8'h24)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .ulpi_data_in  (ulpi_data_in),
    .stp           (stp),
    .ulpi_data_out (ulpi_data_out),
    .dir           (dir),
    .nxt           (nxt),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .tx_last       (tx_last),
    .tx_pid        (tx_pid),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .rx_last       (rx_last),
    .rx_ready      (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; at the falling edge compare {rx_ready,dir,nxt} and the bus,
  // and pop an expected transmit byte whenever tx_valid strobes.
  task automatic step(input logic [7:0] din, input logic s, input logic rv,
                      input logic [7:0] rb, input logic rl,
                      input logic [2:0] ectl, input logic [7:0] edata);
    logic [8:0] exp_tx;
    ulpi_data_in = din;
    stp          = s;
    rx_valid     = rv;
    rx_byte      = rb;
    rx_last      = rl;
    @(negedge clk);
    check("bus", 32'({rx_ready, dir, nxt, ulpi_data_out}), 32'({ectl, edata}));
    if (tx_valid) begin
      if (tx_q.size() == 0) begin
        check("tx_spurious", 32'(tx_valid), 32'(0));
      end else begin
        exp_tx = tx_q.pop_front();
        check("tx_beat", 32'({tx_last, tx_byte}), 32'(exp_tx));
      end
    end else begin
      check("tx_last_idle", 32'(tx_last), 32'(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] cmd, input logic [7:0] exp_data);
    step(cmd,   1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    step(cmd,   1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b010, 8'h00);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b010, exp_data);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
  endtask

  task automatic wr(input logic [7:0] cmd, input logic [7:0] data);
    step(cmd,   1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    step(cmd,   1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(data,  1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
  endtask

  initial begin
    ulpi_data_in = 8'h00;
    stp          = 1'b0;
    rx_byte      = 8'h00;
    rx_valid     = 1'b0;
    rx_last      = 1'b0;
    n_rst        = 1'b0;
    #2;
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_bus", 32'({rx_ready, dir, nxt, ulpi_data_out}), 32'(0));
    check("rst_tx", 32'({tx_valid, tx_last, tx_pid, tx_byte}), 32'(0));
    @(posedge clk);
    #1;
    n_rst = 1'b0;

    // Reset value of register 0, then write/read round trips
    rd(8'hC0, 8'h24);
    wr(8'h85, 8'h5A);
    rd(8'hC5, 8'h5A);
    rd(8'hC7, 8'h00);
    wr(8'h9F, 8'h77);
    rd(8'hDF, 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    rd(8'hC0, 8'h24);

    // Transmit A1 B2 C3 with PID 3
    step(8'h43, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    step(8'h43, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    tx_q.push_back({1'b0, 8'hA1});
    step(8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    tx_q.push_back({1'b0, 8'hB2});
    step(8'hB2, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    tx_q.push_back({1'b1, 8'hC3});
    step(8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    check("tx_pid_3", 32'(tx_pid), 32'(3));
    check("tx_drain_1", 32'(tx_q.size()), 32'(0));

    // Zero-length packet: no tx_valid at all
    step(8'h40, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    step(8'h40, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    check("tx_pid_0", 32'(tx_pid), 32'(0));

    // Receive 11, 22, gap, 33(last); stp while dir=1 is ignored
    step(8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 3'b000, 8'h00);
    step(8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 3'b000, 8'h00);
    step(8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 3'b110, 8'h00);
    step(8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 3'b111, 8'h11);
    step(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111, 8'h22);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b110, 8'h11);
    step(8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 3'b110, 8'h11);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b011, 8'h33);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b010, 8'h01);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);

    // Collision: TXCMD wins, receive follows once the transmit ends
    step(8'h41, 1'b0, 1'b1, 8'hAA, 1'b1, 3'b000, 8'h00);
    step(8'h41, 1'b0, 1'b1, 8'hAA, 1'b1, 3'b001, 8'h00);
    tx_q.push_back({1'b1, 8'hD1});
    step(8'hD1, 1'b0, 1'b1, 8'hAA, 1'b1, 3'b001, 8'h00);
    step(8'h00, 1'b1, 1'b1, 8'hAA, 1'b1, 3'b001, 8'h00);
    step(8'h00, 1'b0, 1'b1, 8'hAA, 1'b1, 3'b000, 8'h00);
    step(8'h00, 1'b0, 1'b1, 8'hAA, 1'b1, 3'b000, 8'h00);
    step(8'h00, 1'b0, 1'b1, 8'hAA, 1'b1, 3'b110, 8'h00);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b011, 8'hAA);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b010, 8'h01);
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    check("tx_pid_1", 32'(tx_pid), 32'(1));
    check("tx_drain_2", 32'(tx_q.size()), 32'(0));

    // Reset mid-transmit after two payload bytes
    step(8'h4E, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 8'h00);
    step(8'h4E, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    step(8'hB2, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 8'h00);
    check("tx_pid_e", 32'(tx_pid), 32'(4'hE));
    ulpi_data_in = 8'hC3;
    n_rst        = 1'b1;
    @(negedge clk);
    check("abort_bus", 32'({rx_ready, dir, nxt, ulpi_data_out}), 32'(0));
    check("abort_tx", 32'({tx_valid, tx_last, tx_pid, tx_byte}), 32'(0));
    @(posedge clk);
    #1;
    ulpi_data_in = 8'h00;
    n_rst        = 1'b0;
    rd(8'hC0, 8'h24);
    rd(8'hC5, 8'h00);
    check("tx_drain_3", 32'(tx_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ulpi_phy_responder.md
Name: ulpi_phy_responder

Overview:
PHY-side responder for the 8-bit ULPI interface; it is the opposite end from the link-side USB state machine. It drives dir/nxt/data and consumes stp/data from the link. It decodes link transmit packets and register accesses, and it turns local receive packets into ULPI receive sequences. It is used as a synthesizable PHY stand-in for loopback and system-level testing.

Parameters:
NUM_REGS, 16, number of implemented ULPI registers (addresses 0..NUM_REGS-1)
VENDOR_ID, 8'h24, reset value of register 0x00

Ports:
clk  in  1  system clock; ULPI domain
n_rst  in  1  asynchronous reset, active-high (asserted = 1)
ulpi_data_in  in  8  bus value driven by the link (link usb_out)
stp  in  1  link stop strobe
ulpi_data_out  out  8  bus value driven by the PHY (link usb_in)
dir  out  1  bus direction, 1 = PHY drives
nxt  out  1  PHY throttle/next strobe
tx_byte  out  8  decoded transmit payload byte
tx_valid  out  1  one-cycle strobe, tx_byte valid
tx_last  out  1  qualifies tx_valid: final byte of packet
tx_pid  out  4  PID from last transmit TXCMD[3:0]
rx_byte  in  8  local receive payload byte
rx_valid  in  1  rx_byte offered
rx_last  in  1  qualifies rx_valid: final byte
rx_ready  out  1  rx_byte consumed this cycle when rx_valid=1

Behaviour:
- One clock; reset is asynchronous and active-high. While n_rst=1, all outputs are 0, the FSM is in IDLE, reg[0]=VENDOR_ID and all other registers are 0.
- All outputs are registered except rx_ready. rx_ready is decoded combinationally from state.
- FSM states: IDLE, TX_ACK, TX_DATA, WR_ACK, WR_DATA, WR_END, RD_ACK, RD_TURN, RD_DATA, RX_TURN, RX_DATA, RX_EOP, RX_BACK.
- TXCMD decode happens in IDLE, with dir=0 and ulpi_data_in[7:6] nonzero:
  - 01 = transmit, go to TX_ACK.
  - 10 = register write, go to WR_ACK.
  - 11 = register read, go to RD_ACK.
  - 00 = idle/NOOP and is ignored.
- Transmit sequence:
  - TX_ACK: nxt=1; the TXCMD is consumed; tx_pid latches cmd[3:0]; go to TX_DATA.
  - TX_DATA: nxt=1. Each byte is held one cycle in a skid register. The held byte is emitted (tx_valid=1, tx_last=0) when the next byte arrives.
  - On stp=1, the held byte is emitted with tx_last=1 and nxt=0. The bus byte during stp is ignored. Return to IDLE.
  - stp in TX_DATA with no held byte (zero-length packet) gives no tx_valid.
- Register write sequence:
  - WR_ACK: nxt=1, address latched from cmd[5:0].
  - WR_DATA: nxt=1, data latched.
  - WR_END: nxt=0, wait for stp. The register is written on the stp cycle, then return to IDLE.
  - Address >= NUM_REGS: the write is dropped.
- Register read sequence:
  - RD_ACK: nxt=1, address latched.
  - RD_TURN: dir=1, data 0.
  - RD_DATA: dir=1, data=reg[addr] (0x00 if addr >= NUM_REGS).
  - Then dir=0 and return to IDLE. Register reads and writes have no side effects on tx_* signals.
- Receive start:
  - IDLE with rx_valid=1 and no TXCMD on the bus: go to RX_TURN.
  - RX_TURN: dir=1, nxt=0, data 0.
  - TXCMD present in the same IDLE cycle wins; the rx request waits.
- Receive data (RX_DATA):
  - rx_ready=1. An accepted byte appears on the bus the next cycle with dir=1, nxt=1.
  - Cycles with rx_valid=0 drive the RXCMD 8'h11 (RxActive=1, LineState=J) with nxt=0.
- Receive end:
  - After the rx_last byte is driven, RX_EOP drives the RXCMD 8'h01 (RxActive=0) with nxt=0.
  - RX_BACK then drives dir=0, data 0, and returns to IDLE. Minimum gap before the next RX_TURN is 1 IDLE cycle.
- stp while dir=1 is ignored. stp in IDLE is ignored.
- n_rst asserted mid-operation aborts immediately. No partial tx_valid and no register write occur.

Test Plan:
1. Reset, then read: pulse n_rst; check dir=nxt=0, data_out=0. Then read cmd 8'hC0 -> nxt=1 for 1 cycle, dir=1 for 2 cycles, data_out=8'h24 on the second of those cycles.
2. Write then read: cmd 8'h85, data 8'h5A, then stp -> nxt=1 for 2 cycles. A read of 8'hC5 returns 8'h5A. A write to 8'h9F (addr 31) followed by a read returns 8'h00.
3. Transmit: TXCMD 8'h43, bytes A1 B2 C3, then stp -> tx_pid=3, tx_valid strobes A1, B2, C3, tx_last only with C3.
4. Receive with gap: offer bytes 11, 22 (rx_valid low 2 cycles), 33 with rx_last set -> bus sequence is turn, 11(nxt), 22(nxt), 8'h11, 8'h11, 33(nxt), 8'h01, then dir falls.
5. Collision: TXCMD 8'h41 and rx_valid in the same IDLE cycle -> transmit served first; receive starts 1 cycle after stp.
6. Reset mid-transmit: after 2 payload bytes, assert n_rst -> no tx_last; all outputs 0 immediately.
